servant_spi_fram_slave: RTL
===========================

// Module: servant_spi_fram_slave
// PURPOSE
//  SPI responder that emulates the serial FRAM driven by the servant SPI flash/FRAM master.
//  Decodes opcodes WREN/WRDI/RDSR/READ/WRITE with a 24-bit address into an on-chip byte array.
//  Used as an on-FPGA stand-in for the external FRAM and as the bench model for master tests.
//  Serial pins are sampled by the system clock; no logic runs on spi_sck.
// PARAMETERS
//  ADDRESS_WIDTH   24  address bits per transaction; three address bytes are always received
//  MEM_DEPTH_LOG2  12  array holds 2**MEM_DEPTH_LOG2 bytes; address bits above this are ignored
//  SYNC_STAGES     2   flip-flop synchroniser depth on spi_sck, spi_ss and spi_mosi
// PORTS
//  clock       in   1  system clock; all state changes on its rising edge
//  reset       in   1  synchronous, active-high reset
//  spi_sck     in   1  serial clock, idles high (mode 3)
//  spi_ss      in   1  chip select, active low
//  spi_mosi    in   1  serial data in, MSB first
//  spi_miso    out  1  serial data out, MSB first
//  wel         out  1  write-enable latch (status bit 1)
//  busy        out  1  high while synchronised spi_ss is low
//  last_cmd    out  8  opcode of the most recent completed command byte
// BEHAVIOUR
//  - Reset: spi_miso=0, wel=0, busy=0, last_cmd=8'h00, FSM=IDLE. Memory contents are NOT cleared.
//  - Input timing: SCK edges are taken from the synchronised spi_sck.
//  - SCK half-period must be >= SYNC_STAGES+2 clocks (master CLOCK_DIVIDER >= 8).
//  - Mode 3: MOSI is sampled on the SCK rise. MISO changes only on the SCK fall, one clock after detection.
//  - Bit counter is 3 bits and is cleared on the SS fall. A byte completes on the 8th rise.
//  - FSM states:
//      IDLE -> CMD on the SS fall.
//      CMD, at byte end:
//        06 -> set wel, then IGNORE
//        04 -> clear wel, then IGNORE
//        05 -> STAT
//        03 -> ADDR(read)
//        02 -> ADDR(write)
//        other -> IGNORE
//      ADDR: 3 bytes, big-endian, into a 24-bit register, then RDATA or WDATA.
//      RDATA: data byte mem[addr] is shifted out from the SCK fall that follows the last address rise.
//        The next byte is loaded at each byte end and addr increments.
//      WDATA: at each byte end, if wel=1, mem[addr] is written and addr increments.
//      STAT: shifts out {6'b0, wel, 1'b0}. Repeats every byte while SS stays low.
//      IGNORE: spi_miso=0 until the SS rise.
//  - Address wraps from 2**MEM_DEPTH_LOG2-1 to 0 within one burst.
//  - Memory read is combinational (distributed RAM), so each byte is valid before its first SCK fall.
//  - SS rise in any state returns to IDLE within SYNC_STAGES+1 clocks and drives spi_miso=0.
//    A partial byte is discarded and never written.
//  - wel is cleared on the SS rise that ends a WRITE command that reached WDATA.
//    This holds even with zero data bytes.
//  - WRITE with wel=0: address and data are clocked in, memory is unchanged, wel stays 0.
//  - Synchronous reset mid-transaction aborts to IDLE. Further bits are ignored until the next SS fall.
//  - last_cmd updates at the end of every CMD byte, including unknown opcodes.
// CONFIGURATION
//  SERVANT_SPI_FRAM_WRPROT_EN defined:
//    - Adds status bits BP[1:0] at [3:2].
//    - Opcode 01 (WRSR) with wel=1 loads BP from data byte bits [3:2], then clears wel on the SS rise.
//    - BP protects: 00 none, 01 upper quarter, 10 upper half, 11 whole array.
//    - Writes to protected addresses are dropped; addr still increments.
//    - BP resets to 00.
//  SERVANT_SPI_FRAM_WRPROT_EN undefined:
//    - 01 is an unknown opcode (IGNORE).
//    - Status bits [3:2] read 0.
//    - No write is ever blocked except by wel.
// TESTING
//  - Reset, then RDSR (05) -> status 8'h00. WREN (06), then RDSR -> 8'h02.
//  - WREN; WRITE 02 000010 AA BB CC; READ 03 000010 plus 3 bytes -> AA BB CC.
//    Status afterwards reads 8'h00.
//  - WRITE 02 000020 55 without WREN -> READ 000020 returns the old value. wel stays 0.
//  - MEM_DEPTH_LOG2=12: WREN; WRITE at 000FFF with 11 22 -> mem[FFF]=11, mem[000]=22.
//    READ 000FFF for 2 bytes -> 11 22.
//  - WREN; WRITE 000030; raise SS after 5 data bits -> mem[30] unchanged, wel=0.
//  - WRPROT_EN: WREN; WRSR 01 0C; WREN; WRITE 000100 77 -> mem[100] unchanged.
//    RDSR -> 8'h0C.

Source files
------------

// File: rtl/servant_spi_fram_slave.sv
// SPI mode-3 FRAM responder: WREN/WRDI/RDSR/READ/WRITE into an on-chip byte array.
// Optional block protection (BP bits, WRSR opcode) under SERVANT_SPI_FRAM_WRPROT_EN.
module servant_spi_fram_slave #(
   parameter int ADDRESS_WIDTH  = 24,
   parameter int MEM_DEPTH_LOG2 = 12,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       spi_sck,
   input  logic       spi_ss,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       wel,
   output logic       busy,
   output logic [7:0] last_cmd
);
   localparam int M = MEM_DEPTH_LOG2;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STAT, IGNORE, WRSR} state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   sck_sync, ss_sync, mosi_sync;
   logic                     sck_d, ss_d;
   logic [2:0]               bit_cnt;
   logic [1:0]               addr_cnt;
   logic [7:0]               rx, tx;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic                     is_rd, wr_seen;
   logic [1:0]               bp;
   logic [7:0]               mem [0:(1<<M)-1];

   // Synchronisers are left out of reset so a reset with SS held low cannot fake an SS fall.
   always_ff @(posedge clock) begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      ss_d      <= ss_sync[SYNC_STAGES-1];
   end

   logic sck_s, ss_s, mosi_s, sck_rise, sck_fall, ss_rise, ss_fall, byte_end;
   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign ss_rise  = ss_s & ~ss_d;
   assign ss_fall  = ~ss_s & ss_d;
   assign byte_end = sck_rise && (bit_cnt == 3'd7);

   logic [7:0]               rx_byte, rd_data, status;
   logic [ADDRESS_WIDTH-1:0] addr_next, addr_inc;
   logic [M-1:0]             rd_idx, wr_idx;
   logic                     prot, mem_we;

   assign rx_byte   = {rx[6:0], mosi_s};
   assign addr_next = {addr[ADDRESS_WIDTH-9:0], rx_byte};
   assign addr_inc  = addr + ADDRESS_WIDTH'(1);
   // The last address byte reads through addr_next so the first data byte is ready for its first fall.
   assign rd_idx    = (state == ADDR) ? addr_next[M-1:0] : addr_inc[M-1:0];
   assign rd_data   = mem[rd_idx];
   assign wr_idx    = addr[M-1:0];
   assign status    = {4'b0000, bp, wel, 1'b0};

   always_comb begin
      prot = 1'b0;
      case (bp)
         2'b01:   prot = &wr_idx[M-1:M-2];
         2'b10:   prot = wr_idx[M-1];
         2'b11:   prot = 1'b1;
         default: prot = 1'b0;
      endcase
   end

   assign mem_we = !reset && (state == WDATA) && byte_end && !ss_rise && !ss_fall && wel && !prot;

   always_ff @(posedge clock) begin
      if (mem_we) mem[wr_idx] <= rx_byte;
   end

`ifndef SERVANT_SPI_FRAM_WRPROT_EN
   assign bp = 2'b00;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         spi_miso <= 1'b0;
         wel      <= 1'b0;
         busy     <= 1'b0;
         last_cmd <= 8'h00;
         bit_cnt  <= 3'd0;
         addr_cnt <= 2'd0;
         rx       <= 8'h00;
         tx       <= 8'h00;
         addr     <= '0;
         is_rd    <= 1'b0;
         wr_seen  <= 1'b0;
`ifdef SERVANT_SPI_FRAM_WRPROT_EN
         bp       <= 2'b00;
`endif
      end else begin
         busy <= ~ss_s;
         if (ss_rise) begin
            state    <= IDLE;
            spi_miso <= 1'b0;
            tx       <= 8'h00;
            wr_seen  <= 1'b0;
            if (wr_seen) wel <= 1'b0;
         end else if (ss_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            spi_miso <= 1'b0;
            tx       <= 8'h00;
            wr_seen  <= 1'b0;
         end else if (state != IDLE) begin
            if (sck_fall) begin
               spi_miso <= tx[7];
               tx       <= {tx[6:0], 1'b0};
            end
            if (sck_rise) begin
               rx      <= rx_byte;
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_end) begin
               case (state)
                  CMD: begin
                     last_cmd <= rx_byte;
                     addr_cnt <= 2'd0;
                     case (rx_byte)
                        8'h06: begin wel <= 1'b1; state <= IGNORE; end
                        8'h04: begin wel <= 1'b0; state <= IGNORE; end
                        8'h05: begin tx <= status; state <= STAT; end
                        8'h03: begin is_rd <= 1'b1; state <= ADDR; end
                        8'h02: begin is_rd <= 1'b0; state <= ADDR; end
`ifdef SERVANT_SPI_FRAM_WRPROT_EN
                        8'h01: begin wr_seen <= 1'b1; state <= WRSR; end
`endif
                        default: state <= IGNORE;
                     endcase
                  end
                  ADDR: begin
                     addr     <= addr_next;
                     addr_cnt <= addr_cnt + 2'd1;
                     if (addr_cnt == 2'd2) begin
                        if (is_rd) begin
                           tx    <= rd_data;
                           state <= RDATA;
                        end else begin
                           wr_seen <= 1'b1;
                           state   <= WDATA;
                        end
                     end
                  end
                  RDATA: begin
                     addr <= addr_inc;
                     tx   <= rd_data;
                  end
                  WDATA: addr <= addr_inc;
                  STAT:  tx <= status;
                  WRSR: begin
`ifdef SERVANT_SPI_FRAM_WRPROT_EN
                     if (wel) bp <= rx_byte[3:2];
`endif
                     state <= IGNORE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule
